// File: rtl/seven_seg_multi.sv
// Multiplexed seven-segment driver: LOAD-captured hex/decimal value, sequential
// double-dabble conversion, leading-zero blanking, overflow dashes and 16-level PWM.
module seven_seg_multi #(
    parameter int DIGITS   = 8,
    parameter int CLK_FREQ = 100000000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  mode_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  blank_lz_i,
    input  logic [3:0]            bright_i,
    input  logic                  load_i,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic [7:0]            cathode_o,
    output logic [DIGITS-1:0]     anode_o
);

    localparam int W      = 4 * DIGITS;
    localparam int E      = DIGITS + (DIGITS + 3) / 4;
    localparam int SLOT   = CLK_FREQ / SCAN_HZ;
    localparam int PH_LEN = SLOT / 16;
    localparam int PCW    = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW     = $clog2(W);

    localparam logic [PCW-1:0] PH_MAX  = PCW'(PH_LEN - 1);
    localparam logic [IW-1:0]  IDX_MAX = IW'(DIGITS - 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [W-1:0]            val_q, val_d;
    logic                    mode_q, mode_d;
    logic [DIGITS-1:0]       dp_q, dp_d;
    logic                    blz_q, blz_d;
    logic [4*E-1:0]          bcd_q, bcd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DIGITS-1:0][7:0]  shadow_q, shadow_d;
    logic                    ovf_q, ovf_d;

    logic [PCW-1:0]          ph_cnt_q, ph_cnt_d;
    logic [3:0]              phase_q, phase_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              cathode_q, cathode_d;
    logic [DIGITS-1:0]       anode_q, anode_d;

    logic [4*E-1:0]          bcd_adj;
    logic [DIGITS-1:0][3:0]  nib_c;
    logic [DIGITS-1:0][7:0]  commit_sh;
    logic                    commit_ovf;
    logic                    lead;
    logic [6:0]              seg;
    logic                    ph_wrap, slot_wrap;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h67;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Double-dabble correction: every BCD digit above 4 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < E; k++) begin
            if (bcd_q[4*k +: 4] > 4'd4)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Shadow image for the commit; blanking walks down from the top digit.
    always_comb begin
        commit_ovf = mode_q && (bcd_q[4*E-1:W] != '0);
        lead       = 1'b1;
        seg        = 7'h00;
        nib_c      = '0;
        commit_sh  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib_c[i] = mode_q ? bcd_q[4*i +: 4] : val_q[4*i +: 4];
            if (commit_ovf)
                seg = 7'h40;
            else if (blz_q && lead && (nib_c[i] == 4'h0) && (i != 0))
                seg = 7'h00;
            else
                seg = glyph(nib_c[i]);
            if (nib_c[i] != 4'h0)
                lead = 1'b0;
            commit_sh[i] = {dp_q[i], seg};
        end
    end

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        mode_d   = mode_q;
        dp_d     = dp_q;
        blz_d    = blz_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (load_i) begin
                    val_d   = value_i;
                    mode_d  = mode_i;
                    dp_d    = dp_i;
                    blz_d   = blank_lz_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = mode_i ? S_CONV : S_COMMIT;
                end
            end
            S_CONV: begin
                bcd_d = {bcd_adj[4*E-2:0], val_q[W-1]};
                val_d = {val_q[W-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_MAX)
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                shadow_d = commit_sh;
                ovf_d    = commit_ovf;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan timing: PH_LEN cycles per phase, 16 phases per digit slot.
    always_comb begin
        ph_wrap   = (ph_cnt_q == PH_MAX);
        slot_wrap = ph_wrap && (phase_q == 4'hF);
        ph_cnt_d  = ph_wrap ? '0 : ph_cnt_q + PCW'(1);
        phase_d   = ph_wrap ? phase_q + 4'd1 : phase_q;
        idx_d     = idx_q;
        if (slot_wrap)
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end

    always_comb begin
        cathode_d = 8'hFF;
        anode_d   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cathode_d  = ~shadow_q[i];
                anode_d[i] = ~(phase_q <= bright_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            val_q     <= '0;
            mode_q    <= 1'b0;
            dp_q      <= '0;
            blz_q     <= 1'b0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            ovf_q     <= 1'b0;
            ph_cnt_q  <= '0;
            phase_q   <= '0;
            idx_q     <= '0;
            cathode_q <= 8'hFF;
            anode_q   <= '1;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            mode_q    <= mode_d;
            dp_q      <= dp_d;
            blz_q     <= blz_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            ovf_q     <= ovf_d;
            ph_cnt_q  <= ph_cnt_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            cathode_q <= cathode_d;
            anode_q   <= anode_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign overflow_o = ovf_q;
    assign cathode_o  = cathode_q;
    assign anode_o    = anode_q;

endmodule

// File: tb/tb_seven_seg_multi.sv
// Directed bench for seven_seg_multi with DIGITS=8 and one cycle per PWM phase.
module tb_seven_seg_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        mode;
    logic [7:0]  dp;
    logic        blz;
    logic [3:0]  bright;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [7:0]  cathode;
    logic [7:0]  anode;

    int checks   = 0;
    int failures = 0;
    logic [63:0] capd;

    seven_seg_multi #(.DIGITS(8), .CLK_FREQ(1600), .SCAN_HZ(100)) dut (
        .clk_i(clk), .reset_i(reset), .value_i(value), .mode_i(mode), .dp_i(dp),
        .blank_lz_i(blz), .bright_i(bright), .load_i(load), .busy_o(busy),
        .overflow_o(ovf), .cathode_o(cathode), .anode_o(anode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] value;
        logic [7:0]  dp;
        logic        blz;
        logic [63:0] glyphs;   // active-high, digit 7 in the top byte
        logic        ovf;
        int          busy;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic m, input logic [31:0] v, input logic [7:0] d,
                           input logic b, output int bc);
        mode = m; value = v; dp = d; blz = b; load = 1'b1;
        tick();
        load = 1'b0;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            tick();
        end
    endtask

    // One full scan plus margin; records the cathode seen for each active anode.
    task automatic capture();
        capd = '0;
        for (int c = 0; c < 140; c++) begin
            tick();
            for (int k = 0; k < 8; k++)
                if (!anode[k]) capd[8*k +: 8] = cathode;
        end
    endtask

    task automatic bright_test(input logic [3:0] b);
        int cnt[8];
        bright = b;
        tick(); tick();
        for (int k = 0; k < 8; k++) cnt[k] = 0;
        for (int c = 0; c < 128; c++) begin
            tick();
            for (int k = 0; k < 8; k++)
                if (!anode[k]) cnt[k]++;
        end
        for (int k = 0; k < 8; k++)
            chk($sformatf("pwm_b%0d_d%0d", b, k), 64'(cnt[k]), 64'(int'(b) + 1));
    endtask

    initial begin
        int bc, pos, prev, run;
        logic bad_scan, bad_static;

        vecs[0] = '{1'b0, 32'h0012ABCD, 8'h00, 1'b0, 64'h3F3F_065B_777C_395E, 1'b0, 1};
        vecs[1] = '{1'b1, 32'd12345678, 8'h00, 1'b0, 64'h065B_4F66_6D7D_077F, 1'b0, 33};
        vecs[2] = '{1'b1, 32'd0,        8'h00, 1'b1, 64'h0000_0000_0000_003F, 1'b0, 33};
        vecs[3] = '{1'b1, 32'd100000000,8'h04, 1'b0, 64'h4040_4040_40C0_4040, 1'b1, 33};
        vecs[4] = '{1'b0, 32'h000000F0, 8'h04, 1'b1, 64'h0000_0000_0080_713F, 1'b0, 1};
        vecs[5] = '{1'b1, 32'd99999999, 8'h00, 1'b0, 64'h6767_6767_6767_6767, 1'b0, 33};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 8'hFF, 1'b0, 64'hF1F1_F1F1_F1F1_F1F1, 1'b0, 1};
        vecs[7] = '{1'b1, 32'd1000,     8'h00, 1'b1, 64'h0000_0000_063F_3F3F, 1'b0, 33};

        reset = 1'b1; value = '0; mode = 1'b0; dp = '0; blz = 1'b0;
        bright = 4'd15; load = 1'b0;
        tick(); tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_cathode", 64'(cathode), 64'hFF);
        chk("rst_anode", 64'(anode), 64'hFF);
        reset = 1'b0;

        // Idle scan: one-hot anode advancing every 16 cycles, display blank.
        bad_scan = 1'b0; bad_static = 1'b0; prev = 0; run = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (!$onehot(~anode)) bad_scan = 1'b1;
            if (cathode !== 8'hFF || busy !== 1'b0 || ovf !== 1'b0) bad_static = 1'b1;
            pos = 0;
            for (int k = 0; k < 8; k++) if (!anode[k]) pos = k;
            if (c == 0) begin
                if (pos != 0) bad_scan = 1'b1;
                prev = pos; run = 1;
            end else if (pos == prev) begin
                run++;
            end else begin
                if (pos != (prev + 1) % 8 || run != 16) bad_scan = 1'b1;
                prev = pos; run = 1;
            end
        end
        chk("idle_scan_order", 64'(bad_scan), 64'd0);
        chk("idle_static", 64'(bad_static), 64'd0);

        for (int v = 0; v < 8; v++) begin
            do_load(vecs[v].mode, vecs[v].value, vecs[v].dp, vecs[v].blz, bc);
            chk($sformatf("v%0d_busy_cycles", v), 64'(bc), 64'(vecs[v].busy));
            chk($sformatf("v%0d_ovf", v), 64'(ovf), 64'(vecs[v].ovf));
            capture();
            chk($sformatf("v%0d_display", v), capd, ~vecs[v].glyphs);
        end

        bright_test(4'd3);
        bright_test(4'd15);
        bright_test(4'd0);
        bright = 4'd15;

        // LOAD during conversion must be ignored.
        mode = 1'b1; value = 32'd12345678; dp = '0; blz = 1'b0; load = 1'b1;
        tick();
        load = 1'b0; bc = 0;
        while (busy && bc < 100) begin
            bc++;
            if (bc == 5) begin
                load = 1'b1; mode = 1'b0; value = 32'h11111111;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        chk("ignore_busy_cycles", 64'(bc), 64'd33);
        capture();
        chk("ignore_display", capd, ~64'h065B_4F66_6D7D_077F);

        // Reset in the middle of a decimal conversion.
        mode = 1'b1; value = 32'd99999999; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        chk("midconv_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cathode", 64'(cathode), 64'hFF);
        chk("abort_anode", 64'(anode), 64'hFF);
        do_load(1'b1, 32'd1000, 8'h00, 1'b0, bc);
        chk("after_abort_busy", 64'(bc), 64'd33);
        chk("after_abort_ovf", 64'(ovf), 64'd0);
        capture();
        chk("after_abort_display", capd, ~64'h3F3F_3F3F_063F_3F3F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
